// File: rtl/sys_pkg.sv
// sys_pkg: shared types and defaults for the systolic MAC array.
// Lane struct, feeder FSM states and a width helper.
package sys_pkg;

    localparam int SYS_WL     = 32;
    localparam int SYS_VECLEN = 8;

    // One lane beat: acc is the accumulate flag carried on outend.
    typedef struct packed {
        logic [SYS_WL-1:0] value;
        logic              valid;
        logic              acc;
    } lane_t;

    typedef enum logic {
        FD_IDLE = 1'b0,
        FD_SEND = 1'b1
    } fd_state_t;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sys_feeder_buf.sv
// sys_feeder_buf: circular word buffer for one feeder lane.
// Ports: clk/rst, push/push_data, pop, rd_data (comb head), count, wr_ready.
module sys_feeder_buf
    import sys_pkg::*;
#(
    parameter int WL    = SYS_WL,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [WL-1:0] push_data,
    input  logic          pop,
    output logic [WL-1:0] rd_data,
    output logic [CW-1:0] count,
    output logic          wr_ready
);

    logic [WL-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head word is read straight from the array; a word
    // written this cycle is never visible to a pop.
    assign rd_data  = mem[rptr];
    assign wr_ready = (count != CW'(DEPTH));

endmodule

// File: rtl/sys_feeder.sv
// sys_feeder: buffered vector transmitter for one systolic edge lane.
// Ports: clk/rst, ena, go, wr_valid/wr_data/wr_ready,
// outvalue/outvalid/outend (lane), vec_sent, busy.
module sys_feeder
    import sys_pkg::*;
#(
    parameter int WL     = SYS_WL,
    parameter int VECLEN = SYS_VECLEN,
    parameter int DEPTH  = 16,
    parameter int SKEW   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          go,
    input  logic          wr_valid,
    input  logic [WL-1:0] wr_data,
    output logic          wr_ready,
    output logic [WL-1:0] outvalue,
    output logic          outvalid,
    output logic          outend,
    output logic          vec_sent,
    output logic          busy
);

    localparam int CW = cnt_w(DEPTH);
    localparam int IW = $clog2(VECLEN);

    localparam logic [CW:0]   VL_C  = (CW+1)'(VECLEN);
    localparam logic [CW:0]   VL_P1 = (CW+1)'(VECLEN + 1);
    localparam logic [IW-1:0] I_END = IW'(VECLEN - 1);

    typedef struct packed {
        logic [WL-1:0] value;
        logic          valid;
        logic          acc;
    } lane_w_t;

    fd_state_t     state;
    fd_state_t     state_nx;
    logic [IW-1:0] idx;
    logic          idx_last;
    logic          push;
    logic          pop;
    logic          pop_last;
    logic [WL-1:0] rd_data;
    logic [CW-1:0] count;
    logic [CW:0]   cnt_after;
    logic          have_vec;
    logic          keep_vec;

    assign push = wr_valid && wr_ready;

    sys_feeder_buf #(
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .count     (count),
        .wr_ready  (wr_ready)
    );

    // count+push >= VECLEN+1 is the same as
    // (count-1 + accepted write) >= VECLEN.
    assign cnt_after = {1'b0, count} + (CW+1)'(push);
    assign have_vec  = ({1'b0, count} >= VL_C);
    assign keep_vec  = (cnt_after >= VL_P1);
    assign idx_last  = (idx == I_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FD_IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == FD_IDLE): begin
                if (go && have_vec) begin
                    state_nx = FD_SEND;
                end
            end
            (state == FD_SEND): begin
                if (idx_last && !(go && keep_vec)) begin
                    state_nx = FD_IDLE;
                end
            end
            default: state_nx = FD_IDLE;
        endcase
    end

    always_comb begin
        pop      = ena && (state == FD_SEND);
        pop_last = pop && idx_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (pop) begin
            idx <= idx_last ? '0 : idx + 1'b1;
        end
    end

    // Primary lane register, loaded on the pop edge.
    lane_w_t prim;
    logic    prim_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            prim      <= '0;
            prim_last <= 1'b0;
        end else if (ena) begin
            prim.valid <= pop;
            prim.acc   <= pop && (idx != '0);
            prim_last  <= pop_last;
            if (pop) begin
                prim.value <= rd_data;
            end
        end
    end

    // Skew line; tap[SKEW] drives the lane.
    lane_w_t [SKEW:0] tap;
    logic    [SKEW:0] ltap;

    assign tap[0]  = prim;
    assign ltap[0] = prim_last;

    for (genvar i = 1; i <= SKEW; i++) begin : g_skew
        lane_w_t r;
        logic    rl;

        always_ff @(posedge clk) begin
            if (rst) begin
                r  <= '0;
                rl <= 1'b0;
            end else if (ena) begin
                r  <= tap[i-1];
                rl <= ltap[i-1];
            end
        end

        assign tap[i]  = r;
        assign ltap[i] = rl;
    end

    assign outvalue = tap[SKEW].value;
    assign outvalid = tap[SKEW].valid;
    assign outend   = tap[SKEW].acc;

    // The last-word flag holds while frozen; qualifying it
    // with the previous ena makes vec_sent a single pulse.
    logic adv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            adv_q <= 1'b0;
        end else begin
            adv_q <= ena;
        end
    end

    assign vec_sent = ltap[SKEW] && adv_q;

    logic any_vld;

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i <= SKEW; i++) begin
            any_vld = any_vld | tap[i].valid;
        end
    end

    assign busy = (state == FD_SEND) || any_vld;

endmodule

// File: tb/tb_sys_feeder.sv
// tb_sys_feeder: checks sys_feeder (SKEW 0 and 3) against a queue model,
// a vector table and directed multi-cycle sequences.
module tb_sys_feeder;

    localparam int WL = 32;
    localparam int VL = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          go = 1'b0;
    logic          wr_valid = 1'b0;
    logic [WL-1:0] wr_data = '0;

    logic          rdy0, rdy3;
    logic [WL-1:0] v0, v3;
    logic          ov0, ov3, oe0, oe3;
    logic          vs0, vs3, b0, b3;

    always #5 clk = ~clk;

    sys_feeder #(
        .WL(WL), .VECLEN(VL), .DEPTH(DP), .SKEW(0)
    ) u0 (
        .clk(clk), .rst(rst), .ena(ena), .go(go),
        .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(rdy0), .outvalue(v0), .outvalid(ov0),
        .outend(oe0), .vec_sent(vs0), .busy(b0)
    );

    sys_feeder #(
        .WL(WL), .VECLEN(VL), .DEPTH(DP), .SKEW(3)
    ) u3 (
        .clk(clk), .rst(rst), .ena(ena), .go(go),
        .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(rdy3), .outvalue(v3), .outvalid(ov3),
        .outend(oe3), .vec_sent(vs3), .busy(b3)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input int lim);
        int t = 0;
        while (!ov0 && t < lim) begin
            tick();
            t++;
        end
        chk("wait_vld", 32'(ov0), 1);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] value;
        logic        valid;
        logic        acc;
        logic        last;
    } mrec_t;

    logic [31:0] mq[$];
    int          rem = 0;
    mrec_t       sk[4];
    logic        mvs0 = 1'b0;
    logic        mvs3 = 1'b0;

    always @(posedge clk) begin : model
        mrec_t nr;
        logic  pushed;
        if (rst) begin
            mq.delete();
            rem = 0;
            for (int i = 0; i < 4; i++) sk[i] = '0;
            mvs0 = 1'b0;
            mvs3 = 1'b0;
        end else begin
            pushed = wr_valid && (mq.size() < DP);
            if (ena) begin
                nr = '0;
                if (rem > 0) begin
                    nr.value = mq.pop_front();
                    nr.valid = 1'b1;
                    nr.acc   = (rem != VL);
                    nr.last  = (rem == 1);
                    rem--;
                    if (rem == 0 && go &&
                        (mq.size() + int'(pushed)) >= VL)
                        rem = VL;
                end else begin
                    nr.value = sk[0].value;
                    if (go && mq.size() >= VL) rem = VL;
                end
                for (int i = 3; i > 0; i--) sk[i] = sk[i-1];
                sk[0] = nr;
                mvs0 = sk[0].last;
                mvs3 = sk[3].last;
            end else begin
                mvs0 = 1'b0;
                mvs3 = 1'b0;
            end
            if (pushed) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m0_value", v0, sk[0].value);
            chk("m0_valid", 32'(ov0), 32'(sk[0].valid));
            chk("m0_end", 32'(oe0), 32'(sk[0].acc));
            chk("m0_sent", 32'(vs0), 32'(mvs0));
            chk("m0_busy", 32'(b0),
                32'((rem > 0) || sk[0].valid));
            chk("m0_rdy", 32'(rdy0), 32'(mq.size() < DP));
            chk("m3_value", v3, sk[3].value);
            chk("m3_valid", 32'(ov3), 32'(sk[3].valid));
            chk("m3_end", 32'(oe3), 32'(sk[3].acc));
            chk("m3_sent", 32'(vs3), 32'(mvs3));
            chk("m3_busy", 32'(b3),
                32'((rem > 0) || sk[0].valid || sk[1].valid
                    || sk[2].valid || sk[3].valid));
            chk("m3_rdy", 32'(rdy3), 32'(mq.size() < DP));
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        ev;
        logic        ee;
        logic [31:0] eval;
        logic        evs;
        logic        ev3;
    } vec_t;

    vec_t        tbl[20];
    logic [31:0] got[$];
    logic [31:0] held;
    bit          froze;
    int          nv;

    initial begin
        for (int i = 0; i < 20; i++) begin
            tbl[i].wv   = (i < 8);
            tbl[i].wd   = (i < 8) ? 32'(i + 1) : 32'h0;
            tbl[i].ev   = (i >= 9 && i <= 16);
            tbl[i].ee   = (i >= 10 && i <= 16);
            tbl[i].eval = (i < 9) ? 32'h0 :
                          (i <= 16) ? 32'(i - 8) : 32'd8;
            tbl[i].evs  = (i == 16);
            tbl[i].ev3  = (i >= 12);
        end

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_value", v0, 0);
        chk("rst_valid", 32'(ov0), 0);
        chk("rst_end", 32'(oe0), 0);
        chk("rst_sent", 32'(vs0), 0);
        chk("rst_busy", 32'(b0), 0);
        chk("rst_rdy", 32'(rdy0), 1);

        // Single vector, words 1..8.
        ena = 1'b1;
        go  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_valid = tbl[i].wv;
            wr_data  = tbl[i].wd;
            tick();
            chk($sformatf("t%0d_vld", i), 32'(ov0), 32'(tbl[i].ev));
            chk($sformatf("t%0d_end", i), 32'(oe0), 32'(tbl[i].ee));
            chk($sformatf("t%0d_val", i), v0, tbl[i].eval);
            chk($sformatf("t%0d_sent", i), 32'(vs0), 32'(tbl[i].evs));
            chk($sformatf("t%0d_vld3", i), 32'(ov3), 32'(tbl[i].ev3));
        end
        wr_valid = 1'b0;

        // Full buffer, then two back-to-back vectors.
        go = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(i + 1);
            tick();
        end
        chk("full_rdy", 32'(rdy0), 0);
        wr_data = 32'd99;
        tick();
        wr_valid = 1'b0;
        chk("full_vld", 32'(ov0), 0);
        go = 1'b1;
        wait_vld(20);
        for (int k = 0; k < 16; k++) begin
            chk("b2b_vld", 32'(ov0), 1);
            chk("b2b_val", v0, 32'(k + 1));
            chk("b2b_end", 32'(oe0), 32'((k % 8) != 0));
            tick();
        end
        chk("b2b_idle", 32'(ov0), 0);
        chk("b2b_rdy", 32'(rdy0), 1);

        // Freeze ena for 3 cycles mid-vector.
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(21 + i);
            tick();
        end
        wr_valid = 1'b0;
        wait_vld(20);
        got.delete();
        froze = 1'b0;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            if (ov0) got.push_back(v0);
            if (got.size() == 3 && !froze) begin
                froze = 1'b1;
                held  = v0;
                ena   = 1'b0;
                for (int f = 0; f < 3; f++) begin
                    tick();
                    chk("frz_val", v0, held);
                    chk("frz_vld", 32'(ov0), 1);
                end
                ena = 1'b1;
            end
            tick();
        end
        chk("frz_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("frz_ord", (i < got.size()) ? got[i] : 32'hx,
                32'(21 + i));
        chk("frz_idle", 32'(ov0), 0);

        // Drop go at word 3 with 16 words buffered.
        go = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(31 + i);
            tick();
        end
        wr_valid = 1'b0;
        go = 1'b1;
        wait_vld(20);
        got.delete();
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            if (ov0) got.push_back(v0);
            if (got.size() == 3) go = 1'b0;
            tick();
        end
        chk("gol_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("gol_ord", (i < got.size()) ? got[i] : 32'hx,
                32'(31 + i));
        nv = 0;
        repeat (15) begin
            if (ov0) nv++;
            tick();
        end
        chk("gol_nostart", nv, 0);
        go = 1'b1;
        repeat (20) tick();

        // Reset at word 4.
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(51 + i);
            tick();
        end
        wr_valid = 1'b0;
        wait_vld(20);
        for (int t = 0; t < 20 && v0 != 32'd54; t++) tick();
        chk("rst_at4", v0, 54);
        rst = 1'b1;
        tick();
        chk("mrst_val", v0, 0);
        chk("mrst_vld", 32'(ov0), 0);
        chk("mrst_end", 32'(oe0), 0);
        chk("mrst_busy", 32'(b0), 0);
        chk("mrst_sent", 32'(vs0), 0);
        chk("mrst_rdy", 32'(rdy0), 1);
        chk("mrst_vld3", 32'(ov3), 0);
        chk("mrst_busy3", 32'(b3), 0);
        chk("mrst_val3", v3, 0);
        rst = 1'b0;
        nv = 0;
        repeat (10) begin
            if (ov0 || ov3) nv++;
            tick();
        end
        chk("mrst_empty", nv, 0);
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(61 + i);
            tick();
        end
        wr_valid = 1'b0;
        wait_vld(20);
        got.delete();
        for (int c = 0; c < 20 && got.size() < 8; c++) begin
            if (ov0) got.push_back(v0);
            tick();
        end
        chk("fresh_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("fresh_ord", (i < got.size()) ? got[i] : 32'hx,
                32'(61 + i));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            ena      = ($urandom_range(0, 9) < 8);
            go       = ($urandom_range(0, 9) <
                        (((c / 500) % 2) != 0 ? 9 : 4));
            wr_valid = ($urandom_range(0, 9) < 6);
            wr_data  = $urandom;
            tick();
        end
        ena      = 1'b1;
        go       = 1'b1;
        wr_valid = 1'b0;
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sys_feeder.md
# sys_feeder

Stream transmitter for one edge lane of the systolic MAC array. It buffers words written by the tile loader and emits them as fixed-length vectors on the lane protocol consumed by the array's processing elements (`outvalue` / `outvalid` / `outend`). It includes an optional skew delay line so that one instance per row or column produces the diagonal wavefront. One instance drives each weight row and each feature column.

## Interface
Parameters:
- `WL`, 32, word width.
- `VECLEN`, 8, words per vector (dot-product length); legal range ≥ 2.
- `DEPTH`, 16, buffer depth in words; power of 2, ≥ `VECLEN`.
- `SKEW`, 0, extra output register stages (row/column index of this lane).

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `ena` in 1: array-wide advance enable; 0 freezes the transmit side.
- `go` in 1: level; permits starting new vectors.
- `wr_valid` in 1: loader word valid.
- `wr_data` in `WL`: loader word.
- `wr_ready` out 1: buffer can accept a word.
- `outvalue` out `WL`: lane word.
- `outvalid` out 1: lane word valid.
- `outend` out 1: accumulate flag (see Operation).
- `vec_sent` out 1: one-cycle pulse when the last word of a vector leaves the skew line.
- `busy` out 1: FSM is in SEND or the skew line holds a valid word.

## Operation
**Buffer:**
- Circular, `DEPTH` entries, with `count` in 0..`DEPTH`.
- Write is accepted when `wr_valid && wr_ready`, where `wr_ready = (count != DEPTH)`.
- Writes are independent of `ena` and `go`. No write-through into the pop path.

**Lane protocol per vector:**
- Words are sent in write order, one per enabled cycle, with `outvalid=1`.
- `outend=0` on word 0 and `outend=1` on words 1..`VECLEN-1`.
- When not sending, `outvalid=0`, `outend=0`, and `outvalue` holds its last value.
- A PE closes its accumulation on the 1→0 edge of `outend`. The next vector's word 0 (back-to-back) or idle provides that edge.

**FSM:**
- IDLE → SEND when `ena && go && count >= VECLEN`. The word index `idx` is 0.
- In SEND, each `ena` cycle pops one word and increments `idx`.
- When `idx = VECLEN-1`, the FSM checks `go && (count-1 + accepted write) >= VECLEN`:
  - If true, it continues in SEND with `idx=0`, back-to-back, with no bubble.
  - If false, it returns to IDLE.
- Deasserting `go` mid-vector does not abort the vector. The vector always completes.

**Count arithmetic:**
- Simultaneous push and pop leaves `count` unchanged.
- Pointers are log2(`DEPTH`) bits and wrap naturally.

**Enable and reset:**
- `ena=0`: the FSM, `idx`, read pointer, output registers and skew stages all hold.
- `rst`: `count=0`, both pointers 0, FSM IDLE, `idx=0`.
- Reset values of all outputs and skew stages: `outvalue=0`, `outvalid=0`, `outend=0`, `vec_sent=0`, `busy=0`. `wr_ready=1` one cycle after reset.
- A reset mid-vector discards the partial vector and all buffered words.

## Timing
- The primary output register is loaded on the same edge as the pop.
- Lane outputs are registered.
- Latency from the FSM start decision (IDLE with condition true at edge t) to word 0 on the outputs is 1 + `SKEW` enabled cycles.
- The `VECLEN`-th write accepted at edge t makes `count` visible at t+1. Word 0 is therefore visible after edge t+2, with `SKEW=0` and `ena` held high.
- `vec_sent` is asserted in the cycle the last word is visible on the outputs. It is cleared when `ena=0`.
- Throughput is 1 word per enabled cycle. Sustained back-to-back vectors require the loader to keep `count >= VECLEN` at each vector boundary.

## Structure
- Shared package `sys_pkg`: the `WL` default, `VECLEN` default, and the lane struct type `{value, valid, end}`. The same type is used by the PE and the result collector.
- Sub-module `sys_feeder_buf`:
  - circular buffer with `count` and `wr_ready`;
  - push/pop ports and combinational read data.
- The FSM, the `idx` counter and the skew line stay in `sys_feeder`. The skew line is a generate loop of `SKEW` lane-struct registers, each gated by `ena`.

## Test plan
- Reset, then write 8 words 1..8 with `go=1`, `ena=1`, `SKEW=0` → `outvalue` 1..8 on consecutive cycles with `outend` = 0,1,1,1,1,1,1,1; then `outvalid=0`, `outend=0`; `vec_sent` pulses once on word 8.
- Pre-load 16 words with `go=0`, then raise `go` → `wr_ready=0` while full; two vectors go out back-to-back with no bubble; `outend` drops to 0 exactly at word 9.
- Toggle `ena` low for 3 cycles mid-vector → outputs frozen for 3 cycles; word order is intact; no words are lost or duplicated.
- Lower `go` at word 3 → the vector completes; no new vector starts despite `count=8`.
- Set `SKEW=3` → word 0 appears 3 cycles later than with `SKEW=0`; values and flags are otherwise identical.
- Assert `rst` at word 4 → next cycle `outvalid=0`, `outend=0`, `outvalue=0`, `busy=0`, `count=0`; a fresh 8-word load transmits cleanly.
